// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer.
//   state_t          : sequencer states (IDLE, four stage states, FINISH, ERROR)
//   STG_*            : stage indices as reported on stage / err_stage
//   DEFAULT_TIMEOUT  : default per-stage watchdog limit in cycles
//   is_stage()       : true for the four engine-running states
//   stage_idx()      : stage index for a running state
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV1  = 3'd1,
        ST_POOL1  = 3'd2,
        ST_CONV2  = 3'd3,
        ST_POOL2  = 3'd4,
        ST_FINISH = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] STG_CONV1 = 2'd0;
    localparam logic [1:0] STG_POOL1 = 2'd1;
    localparam logic [1:0] STG_CONV2 = 2'd2;
    localparam logic [1:0] STG_POOL2 = 2'd3;

    localparam int unsigned DEFAULT_TIMEOUT = 1048576;

    function automatic logic is_stage(input state_t s);
        return s inside {ST_CONV1, ST_POOL1, ST_CONV2, ST_POOL2};
    endfunction

    function automatic logic [1:0] stage_idx(input state_t s);
        case (s)
            ST_POOL1: return STG_POOL1;
            ST_CONV2: return STG_CONV2;
            ST_POOL2: return STG_POOL2;
            default:  return STG_CONV1;
        endcase
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter at the next edge (applied on every state change)
//   enable   : count while a stage is running
//   expired  : the running stage has reached its last allowed cycle
module stage_watchdog
    import cnn_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Saturates at LAST so a stage that stays put can never wrap back to a
    // "healthy" count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Inference controller: runs conv1 -> pool1 -> conv2 -> pool2 once per go.
//   go / abort            : start request (IDLE only) / cancel run, clear error
//   xxx_start / xxx_done  : one-cycle start pulse to, and completion from, each engine
//   stage, buf_sel        : active stage index and ping-pong buffer select
//   busy, done            : a stage is running / one-cycle inference-complete pulse
//   err, err_stage        : sticky watchdog error and the stage that hung
//   total_cycles          : cycles from conv1 entry through the pool2 done cycle
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 21,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    output logic             conv1_start,
    input  logic             conv1_done,
    output logic             pool1_start,
    input  logic             pool1_done,
    output logic             conv2_start,
    input  logic             conv2_done,
    output logic             pool2_start,
    input  logic             pool2_done,
    output logic [1:0]       stage,
    output logic             buf_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_stage,
    output logic [CNT_W-1:0] total_cycles
);

    state_t           state, state_n;
    logic             act_done;
    logic             wd_expired;
    logic [3:0]       start_n;
    logic [1:0]       stage_n;
    logic [1:0]       err_stage_n;
    logic [CNT_W-1:0] total_n;

    stage_watchdog #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_n != state),
        .enable (is_stage(state)),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Outputs are registered, so everything below is computed for the state
    // being entered (state_n) rather than the current one.
    always_comb begin
        act_done    = 1'b0;
        state_n     = state;
        start_n     = '0;
        stage_n     = '0;
        err_stage_n = '0;
        total_n     = total_cycles;

        case (state)
            ST_CONV1: act_done = conv1_done;
            ST_POOL1: act_done = pool1_done;
            ST_CONV2: act_done = conv2_done;
            ST_POOL2: act_done = pool2_done;
            default:  act_done = 1'b0;
        endcase

        case (state)
            ST_IDLE: if (!abort && go) state_n = ST_CONV1;
            ST_CONV1, ST_POOL1, ST_CONV2, ST_POOL2: begin
                // done outranks an expiring watchdog in the same cycle
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (act_done) begin
                    case (state)
                        ST_CONV1: state_n = ST_POOL1;
                        ST_POOL1: state_n = ST_CONV2;
                        ST_CONV2: state_n = ST_POOL2;
                        default:  state_n = ST_FINISH;
                    endcase
                end else if (wd_expired) begin
                    state_n = ST_ERROR;
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            ST_ERROR:  if (abort) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        if (is_stage(state_n) && state_n != state) begin
            start_n[stage_idx(state_n)] = 1'b1;
        end

        if (is_stage(state_n)) begin
            stage_n = stage_idx(state_n);
        end else if (state_n == ST_FINISH || state_n == ST_ERROR) begin
            stage_n = stage;
        end

        if (state_n == ST_ERROR) begin
            err_stage_n = stage;
        end

        if (state == ST_IDLE && state_n == ST_CONV1) begin
            total_n = '0;
        end else if (is_stage(state)) begin
            total_n = total_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv1_start  <= 1'b0;
            pool1_start  <= 1'b0;
            conv2_start  <= 1'b0;
            pool2_start  <= 1'b0;
            stage        <= '0;
            buf_sel      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_stage    <= '0;
            total_cycles <= '0;
        end else begin
            {pool2_start, conv2_start, pool1_start, conv1_start} <= start_n;
            stage        <= stage_n;
            buf_sel      <= stage_n[0];
            busy         <= is_stage(state_n);
            done         <= (state_n == ST_FINISH);
            err          <= (state_n == ST_ERROR);
            err_stage    <= err_stage_n;
            total_cycles <= total_n;
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
module tb_cnn_layer_sequencer;

    localparam int TIMEOUT = 16;

    typedef int arr4_t [4];

    typedef struct packed {
        int l0, l1, l2, l3;
        bit stray;
        int s0, s1, s2, s3;
        int dn, tot, er, es;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, go, abort;
    logic        conv1_start, pool1_start, conv2_start, pool2_start;
    logic [3:0]  eng_dn, stray_dn;
    logic [1:0]  stage, err_stage;
    logic        buf_sel, busy, done, err;
    logic [31:0] total_cycles;

    int    errors = 0;
    int    checks = 0;
    arr4_t lat;

    cnn_layer_sequencer #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (5),
        .CNT_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .abort       (abort),
        .conv1_start (conv1_start),
        .conv1_done  (eng_dn[0] | stray_dn[0]),
        .pool1_start (pool1_start),
        .pool1_done  (eng_dn[1] | stray_dn[1]),
        .conv2_start (conv2_start),
        .conv2_done  (eng_dn[2] | stray_dn[2]),
        .pool2_start (pool2_start),
        .pool2_done  (eng_dn[3] | stray_dn[3]),
        .stage       (stage),
        .buf_sel     (buf_sel),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_stage   (err_stage),
        .total_cycles(total_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] outvec();
        return {conv1_start, pool1_start, conv2_start, pool2_start, stage, buf_sel,
                busy, done, err, err_stage, total_cycles};
    endfunction

    task automatic check(input string what, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [case %0d]: got %0d, required %0d", what, id, act, exp);
        end
    endtask

    // Engines: each answers its start pulse with done lat[i] cycles later.
    task automatic engine();
        bit         pend [4];
        int         cnt  [4];
        logic [3:0] st;
        forever begin
            @(negedge clk);
            st = {pool2_start, conv2_start, pool1_start, conv1_start};
            for (int i = 0; i < 4; i++) begin
                eng_dn[i] = 1'b0;
                if (!busy) pend[i] = 1'b0;
                if (st[i]) begin
                    pend[i] = 1'b1;
                    cnt[i]  = lat[i];
                end
                if (pend[i]) begin
                    if (cnt[i] == 0) begin
                        eng_dn[i] = 1'b1;
                        pend[i]   = 1'b0;
                    end else begin
                        cnt[i]--;
                    end
                end
            end
        end
    endtask

    // Reference: each stage lasts latency+1 cycles; a latency of TIMEOUT or
    // more means the stage errors TIMEOUT cycles after its entry.
    function automatic void model(input arr4_t l, output arr4_t s, output int dn,
                                  output int tot, output int er, output int es);
        int t;
        t = 1;
        s = '{-1, -1, -1, -1};
        dn = -1; tot = 0; er = -1; es = 0;
        for (int i = 0; i < 4; i++) begin
            s[i] = t;
            if (l[i] < TIMEOUT) begin
                t += l[i] + 1;
            end else begin
                er = t + TIMEOUT;
                es = i;
                return;
            end
        end
        dn  = t;
        tot = t - 1;
    endfunction

    // go in cycle 0, then observe; an error is answered with one abort cycle.
    task automatic run_case(input int id, input arr4_t l, input bit stray, input arr4_t es_,
                            input int edn, input int etot, input int eer, input int ees);
        arr4_t      os, obuf, ostg;
        int         extra, odn, otot, obdn, oer, oes, oberr, post, epost;
        logic [3:0] st;
        extra = 0; odn = -1; otot = -1; obdn = -1; oer = -1; oes = -1; oberr = -1;
        post = -1; epost = -1;
        for (int i = 0; i < 4; i++) begin
            os[i] = -1; obuf[i] = -1; ostg[i] = -1;
        end
        lat = l;
        @(negedge clk);
        go = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            go = 1'b0; abort = 1'b0; stray_dn = '0;
            if (odn >= 0) begin
                post = int'({done, busy, stage});
                break;
            end
            if (oer >= 0) begin
                epost = int'({err, err_stage, busy});
                break;
            end
            st = {pool2_start, conv2_start, pool1_start, conv1_start};
            for (int i = 0; i < 4; i++) begin
                if (st[i]) begin
                    if (os[i] < 0) begin
                        os[i] = c; obuf[i] = int'(buf_sel); ostg[i] = int'(stage);
                    end else begin
                        extra++;
                    end
                end
            end
            if (done) begin
                odn = c; otot = int'(total_cycles); obdn = int'(busy);
            end
            if (err) begin
                oer = c; oes = int'(err_stage); oberr = int'(busy); abort = 1'b1;
            end
            if (stray && c == 3) stray_dn = 4'b0110;
            if (stray && c == 5) stray_dn = 4'b1000;
        end
        go = 1'b0; abort = 1'b0; stray_dn = '0;

        check("conv1_start cycle", id, os[0], es_[0]);
        check("pool1_start cycle", id, os[1], es_[1]);
        check("conv2_start cycle", id, os[2], es_[2]);
        check("pool2_start cycle", id, os[3], es_[3]);
        for (int i = 0; i < 4; i++) begin
            if (es_[i] >= 0 && os[i] >= 0) begin
                check("buf_sel at start", id, obuf[i], i % 2);
                check("stage at start", id, ostg[i], i);
            end
        end
        check("extra start pulses", id, extra, 0);
        check("done cycle", id, odn, edn);
        if (edn >= 0) begin
            check("total_cycles", id, otot, etot);
            check("busy during done", id, obdn, 0);
            check("done/busy/stage after finish", id, post, 0);
        end
        check("err cycle", id, oer, eer);
        if (eer >= 0) begin
            check("err_stage", id, oes, ees);
            check("busy in error", id, oberr, 0);
            check("err/err_stage/busy after abort", id, epost, 0);
        end
    endtask

    vec_t  tbl [7];
    arr4_t l, s, nominal_s;
    int    dn, tot, er, es, n_c1, n_done;
    bit    strayb;

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; go = 1'b0; abort = 1'b0; stray_dn = '0; eng_dn = '0;
        lat = '{0, 0, 0, 0};
        nominal_s = '{1, 12, 18, 29};
        fork
            engine();
        join_none

        //            l0 l1  l2    l3 stray s0 s1  s2  s3  dn  tot er  es
        tbl[0] = '{10, 5,  10,   5, 1'b0, 1, 12, 18, 29, 35, 34, -1, 0};
        tbl[1] = '{10, 5,  10,   5, 1'b1, 1, 12, 18, 29, 35, 34, -1, 0};
        tbl[2] = '{10, 15, 10,   5, 1'b0, 1, 12, 28, 39, 45, 44, -1, 0};
        tbl[3] = '{10, 5,  1000, 5, 1'b0, 1, 12, 18, -1, -1, 0,  34, 2};
        tbl[4] = '{0,  0,  0,    0, 1'b0, 1, 2,  3,  4,  5,  4,  -1, 0};
        tbl[5] = '{16, 0,  0,    0, 1'b0, 1, -1, -1, -1, -1, 0,  17, 0};
        tbl[6] = '{0,  0,  0,   15, 1'b0, 1, 2,  3,  4,  20, 19, -1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs in reset", 0, int'(outvec() != '0), 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            l = '{tbl[k].l0, tbl[k].l1, tbl[k].l2, tbl[k].l3};
            s = '{tbl[k].s0, tbl[k].s1, tbl[k].s2, tbl[k].s3};
            run_case(k, l, tbl[k].stray, s, tbl[k].dn, tbl[k].tot, tbl[k].er, tbl[k].es);
        end

        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) begin
                l[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 19))
                                                    : int'($urandom_range(0, 15));
            end
            strayb = (l[0] >= 3) && ($urandom_range(0, 1) == 1);
            model(l, s, dn, tot, er, es);
            run_case(100 + k, l, strayb, s, dn, tot, er, es);
        end

        // abort and go in the same IDLE cycle: nothing starts
        @(negedge clk);
        go = 1'b1; abort = 1'b1;
        n_c1 = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            go = 1'b0; abort = 1'b0;
            if (conv1_start || busy) n_c1++;
        end
        check("abort beats go in IDLE", 200, n_c1, 0);

        // go during POOL1 ignored, abort during CONV2
        lat = '{10, 5, 10, 5};
        n_c1 = 0; n_done = 0;
        @(negedge clk);
        go = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            go = 1'b0; abort = 1'b0;
            if (conv1_start) n_c1++;
            if (done) n_done++;
            if (c == 14) go = 1'b1;
            if (c == 15) check("stage after go in POOL1", 201, int'(stage), 1);
            if (c == 20) abort = 1'b1;
            if (c == 21) begin
                check("busy after abort", 201, int'(busy), 0);
                check("stage after abort", 201, int'(stage), 0);
                check("total after abort", 201, int'(total_cycles), 20);
            end
            if (c == 25) check("total holds after abort", 201, int'(total_cycles), 20);
        end
        check("conv1_start count", 201, n_c1, 1);
        check("done pulses after abort", 201, n_done, 0);
        run_case(202, '{10, 5, 10, 5}, 1'b0, nominal_s, 35, 34, -1, 0);

        // reset during POOL2
        lat = '{10, 5, 10, 5};
        @(negedge clk);
        go = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (c == 31) begin
                check("busy in POOL2", 203, int'(busy), 1);
                rst = 1'b1;
            end
            if (c == 32) begin
                check("outputs after mid-run reset", 203, int'(outvec() != '0), 0);
                rst = 1'b0;
            end
        end
        run_case(204, '{10, 5, 10, 5}, 1'b0, nominal_s, 35, 34, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
